// File: rtl/osiris_pkg.sv
// Osiris shared datapath definitions.
// Default width, occupancy encoding and select-width helper.
package osiris_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer.
// Main register drives the output; skid catches one beat under stall.
module skid_buffer
  import osiris_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  occ_e             state;
  occ_e             state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             xfer;
  logic             load_main;
  logic             load_skid;
  logic             skid_to_main;

  // ready comes straight from state so no i_ready path reaches upstream
  assign o_ready = (state != OCC_FULL);
  assign o_valid = (state != OCC_EMPTY);
  assign o_data  = main_q;
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= OCC_EMPTY;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (i_flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state)
        OCC_EMPTY: begin
          if (accept) begin
            state_d   = OCC_ONE;
            load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && xfer) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = OCC_FULL;
          end else if (xfer) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (xfer) begin
            skid_to_main = 1'b1;
            state_d      = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= i_data;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= i_data;
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-input registered selector with valid/ready handshake.
// Out-of-range selects fall back to input 0 and flag the beat.
module mux_nx1_pipe
  import osiris_pkg::*;
#(
  parameter  int WIDTH    = XLEN,
  parameter  int N_INPUTS = 3,
  localparam int SEL_W    = sel_w(N_INPUTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [N_INPUTS*WIDTH-1:0] i_data,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WIDTH-1:0]          o_mux,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_sel_err
);

  localparam int PW = WIDTH + SEL_W + 1;

  logic             in_range;
  logic [WIDTH-1:0] mux_d;
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    pay_out;

  if ((1 << SEL_W) == N_INPUTS) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (int'(i_sel) < N_INPUTS);
  end

  always_comb begin
    mux_d = i_data[WIDTH-1:0];
    for (int k = 0; k < N_INPUTS; k++) begin
      if (in_range && int'(i_sel) == k)
        mux_d = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign pay_in = {!in_range, i_sel, mux_d};

  skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (pay_in),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (pay_out)
  );

  assign {o_sel_err, o_sel, o_mux} = pay_out;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed and scoreboard bench for mux_nx1_pipe.
// Four parameterisations share clock, reset and flush.
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        v3, r3o, rdy3, ov3, err3;
  logic [1:0]  s3, os3;
  logic [95:0] d3;
  logic [31:0] m3;

  logic        v1, r1o, rdy1, ov1, err1;
  logic [0:0]  s1, os1;
  logic [7:0]  d1, m1;

  logic        v4, r4o, rdy4, ov4, err4;
  logic [1:0]  s4, os4;
  logic [63:0] d4;
  logic [15:0] m4;

  logic          v16, r16o, rdy16, ov16, err16;
  logic [3:0]    s16, os16;
  logic [1023:0] d16;
  logic [63:0]   m16;

  mux_nx1_pipe dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(v3), .o_ready(r3o),
    .i_sel(s3), .i_data(d3), .i_flush(flush), .o_valid(ov3),
    .i_ready(rdy3), .o_mux(m3), .o_sel(os3), .o_sel_err(err3)
  );

  mux_nx1_pipe #(.WIDTH(8), .N_INPUTS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1o),
    .i_sel(s1), .i_data(d1), .i_flush(flush), .o_valid(ov1),
    .i_ready(rdy1), .o_mux(m1), .o_sel(os1), .o_sel_err(err1)
  );

  mux_nx1_pipe #(.WIDTH(16), .N_INPUTS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(r4o),
    .i_sel(s4), .i_data(d4), .i_flush(flush), .o_valid(ov4),
    .i_ready(rdy4), .o_mux(m4), .o_sel(os4), .o_sel_err(err4)
  );

  mux_nx1_pipe #(.WIDTH(64), .N_INPUTS(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(r16o),
    .i_sel(s16), .i_data(d16), .i_flush(flush), .o_valid(ov16),
    .i_ready(rdy16), .o_mux(m16), .o_sel(os16), .o_sel_err(err16)
  );

  localparam logic [31:0] A = 32'h11111111;
  localparam logic [31:0] B = 32'h22222222;
  localparam logic [31:0] C = 32'h33333333;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; v3 = 1'b1; s3 = 2'd1; rdy3 = 1'b1;
    tick; tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", ov3); end
    total++; if (m3 !== 32'h0) begin bad++; $display("FAIL rst_mux got=%0h exp=0", m3); end
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", err3); end
    total++; if (os3 !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0h exp=0", os3); end
    total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL rst_valid16 got=%0h exp=0", ov16); end
    rst = 1'b0; v3 = 1'b0;
    tick;
    total++; if (r3o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", r3o); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rst_no_beat got=%0h exp=0", ov3); end
  endtask

  task automatic test_streaming;
    logic [1:0]  sq [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    logic [31:0] eq [4] = '{A, B, C, B};
    rdy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v3 = 1'b1; s3 = sq[i];
      tick;
      total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, ov3); end
      total++; if (m3 !== eq[i]) begin bad++; $display("FAIL stream_mux[%0d] got=%0h exp=%0h", i, m3, eq[i]); end
      total++; if (os3 !== sq[i]) begin bad++; $display("FAIL stream_sel[%0d] got=%0h exp=%0h", i, os3, sq[i]); end
      total++; if (err3 !== 1'b0) begin bad++; $display("FAIL stream_err[%0d] got=%0h exp=0", i, err3); end
      total++; if (r3o !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0h exp=1", i, r3o); end
    end
    v3 = 1'b0;
    tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL stream_idle got=%0h exp=0", ov3); end
  endtask

  task automatic test_out_of_range;
    rdy3 = 1'b1; v3 = 1'b1; s3 = 2'd3;
    tick;
    total++; if (m3 !== A) begin bad++; $display("FAIL oor_mux got=%0h exp=%0h", m3, A); end
    total++; if (os3 !== 2'd3) begin bad++; $display("FAIL oor_sel got=%0h exp=3", os3); end
    total++; if (err3 !== 1'b1) begin bad++; $display("FAIL oor_err got=%0h exp=1", err3); end
    s3 = 2'd2;
    tick;
    total++; if (m3 !== C) begin bad++; $display("FAIL oor_next_mux got=%0h exp=%0h", m3, C); end
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL oor_next_err got=%0h exp=0", err3); end
    v3 = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    rdy3 = 1'b0; v3 = 1'b1; s3 = 2'd0;
    tick;
    total++; if (m3 !== A || r3o !== 1'b1) begin bad++; $display("FAIL bp_a mux=%0h rdy=%0h exp=%0h/1", m3, r3o, A); end
    s3 = 2'd1;
    tick;
    total++; if (r3o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0h exp=0", r3o); end
    total++; if (m3 !== A) begin bad++; $display("FAIL bp_hold1 got=%0h exp=%0h", m3, A); end
    s3 = 2'd2;
    tick;
    total++; if (m3 !== A || os3 !== 2'd0) begin bad++; $display("FAIL bp_hold2 mux=%0h sel=%0h exp=%0h/0", m3, os3, A); end
    total++; if (r3o !== 1'b0) begin bad++; $display("FAIL bp_c_held got=%0h exp=0", r3o); end
    rdy3 = 1'b1;
    tick;
    total++; if (m3 !== B || ov3 !== 1'b1) begin bad++; $display("FAIL bp_b mux=%0h v=%0h exp=%0h/1", m3, ov3, B); end
    total++; if (r3o !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0h exp=1", r3o); end
    tick;
    total++; if (m3 !== C || os3 !== 2'd2) begin bad++; $display("FAIL bp_c mux=%0h sel=%0h exp=%0h/2", m3, os3, C); end
    v3 = 1'b0;
    tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0h exp=0", ov3); end
  endtask

  task automatic test_flush;
    rdy3 = 1'b0; v3 = 1'b1; s3 = 2'd0;
    tick;
    s3 = 2'd1;
    tick;
    s3 = 2'd2; flush = 1'b1;
    tick;
    flush = 1'b0; v3 = 1'b0;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%0h exp=0", ov3); end
    total++; if (r3o !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%0h exp=1", r3o); end
    rdy3 = 1'b1;
    tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_full_ghost got=%0h exp=0", ov3); end
    rdy3 = 1'b0; v3 = 1'b1; s3 = 2'd0;
    tick;
    total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL flush_one_fill got=%0h exp=1", ov3); end
    s3 = 2'd1; flush = 1'b1;
    tick;
    flush = 1'b0; v3 = 1'b0;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_acc_valid got=%0h exp=0", ov3); end
    total++; if (r3o !== 1'b1) begin bad++; $display("FAIL flush_acc_ready got=%0h exp=1", r3o); end
    rdy3 = 1'b1;
    tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL flush_acc_ghost got=%0h exp=0", ov3); end
  endtask

  task automatic test_reset_mid;
    rdy3 = 1'b0; v3 = 1'b1; s3 = 2'd2;
    tick;
    s3 = 2'd1;
    tick;
    rst = 1'b1;
    tick;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0h exp=0", ov3); end
    total++; if (m3 !== 32'h0 || os3 !== 2'd0) begin bad++; $display("FAIL rmid_data mux=%0h sel=%0h exp=0/0", m3, os3); end
    rst = 1'b0; v3 = 1'b0; rdy3 = 1'b1;
    tick;
    total++; if (r3o !== 1'b1 || ov3 !== 1'b0) begin bad++; $display("FAIL rmid_after rdy=%0h v=%0h exp=1/0", r3o, ov3); end
  endtask

  task automatic test_n1;
    d1 = 8'hA5; rdy1 = 1'b1; v1 = 1'b1; s1 = 1'b1;
    tick;
    total++; if (m1 !== 8'hA5) begin bad++; $display("FAIL n1_oor_mux got=%0h exp=a5", m1); end
    total++; if (err1 !== 1'b1 || os1 !== 1'b1) begin bad++; $display("FAIL n1_oor_err err=%0h sel=%0h exp=1/1", err1, os1); end
    s1 = 1'b0;
    tick;
    total++; if (m1 !== 8'hA5 || err1 !== 1'b0) begin bad++; $display("FAIL n1_ok mux=%0h err=%0h exp=a5/0", m1, err1); end
    v1 = 1'b0;
    tick;
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL n1_idle got=%0h exp=0", ov1); end
  endtask

  task automatic test_n4;
    logic [15:0] e4 [4] = '{16'h1a11, 16'h2b22, 16'h3c33, 16'h4d44};
    d4 = {16'h4d44, 16'h3c33, 16'h2b22, 16'h1a11};
    rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1; s4 = 2'(i);
      tick;
      total++; if (m4 !== e4[i] || os4 !== 2'(i)) begin bad++; $display("FAIL n4_mux[%0d] mux=%0h sel=%0h exp=%0h", i, m4, os4, e4[i]); end
      total++; if (err4 !== 1'b0 || ov4 !== 1'b1) begin bad++; $display("FAIL n4_err[%0d] err=%0h v=%0h exp=0/1", i, err4, ov4); end
    end
    v4 = 1'b0;
    tick;
    total++; if (r4o !== 1'b1 || ov4 !== 1'b0) begin bad++; $display("FAIL n4_idle rdy=%0h v=%0h exp=1/0", r4o, ov4); end
  endtask

  task automatic test_n16_random;
    logic [67:0]   q [$];
    logic [67:0]   exp_b;
    logic [1023:0] sh;
    logic          m_rdy;
    logic          m_vld;
    for (int c = 0; c < 404; c++) begin
      v16   = (c < 400) && ($urandom_range(0, 3) != 0);
      rdy16 = (c >= 400) || ($urandom_range(0, 2) != 0);
      s16   = 4'($urandom_range(0, 15));
      for (int k = 0; k < 32; k++) d16 = {d16[991:0], 32'($urandom)};
      m_vld = (q.size() != 0);
      m_rdy = (q.size() < 2);
      total++; if (ov16 !== m_vld) begin bad++; $display("FAIL n16_valid[%0d] got=%0h exp=%0h", c, ov16, m_vld); end
      total++; if (r16o !== m_rdy) begin bad++; $display("FAIL n16_ready[%0d] got=%0h exp=%0h", c, r16o, m_rdy); end
      if (m_vld && rdy16) begin
        exp_b = q.pop_front();
        total++;
        if ({os16, m16} !== exp_b || err16 !== 1'b0) begin
          bad++;
          $display("FAIL n16_beat[%0d] got=%0h/%0h exp=%0h/0", c, {os16, m16}, err16, exp_b);
        end
      end
      if (v16 && m_rdy) begin
        sh = d16 >> (int'(s16) * 64);
        q.push_back({s16, sh[63:0]});
      end
      tick;
    end
    v16 = 1'b0;
    total++; if (ov16 !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL n16_drain v=%0h left=%0d exp=0/0", ov16, q.size()); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    v3 = 1'b0; s3 = '0; rdy3 = 1'b1; d3 = {C, B, A};
    v1 = 1'b0; s1 = '0; rdy1 = 1'b1; d1 = '0;
    v4 = 1'b0; s4 = '0; rdy4 = 1'b1; d4 = '0;
    v16 = 1'b0; s16 = '0; rdy16 = 1'b1; d16 = '0;
    test_reset;
    test_streaming;
    test_out_of_range;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_n1;
    test_n4;
    test_n16_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
